// File: rtl/draw_line_queued.sv
// Bresenham line engine fed by a small command FIFO. Queued segments are
// rasterised back-to-back, one pixel per cycle while oe is high, each line
// carrying its own colour through to the pixel output.
module draw_line_queued #(
  parameter int CORDW = 16,
  parameter int COLW  = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CORDW-1:0] cmd_x0,
  input  logic [CORDW-1:0] cmd_y0,
  input  logic [CORDW-1:0] cmd_x1,
  input  logic [CORDW-1:0] cmd_y1,
  input  logic [COLW-1:0]  cmd_col,
  input  logic             oe,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic [COLW-1:0]  col,
  output logic             drawing,
  output logic             line_done,
  output logic             idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // two extra bits keep 2*err signed and free of overflow for full-range coords
  localparam int EW = CORDW + 2;

  typedef struct packed {
    logic [CORDW-1:0] x0;
    logic [CORDW-1:0] y0;
    logic [CORDW-1:0] x1;
    logic [CORDW-1:0] y1;
    logic [COLW-1:0]  col;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  cmd_t                 mem_q [DEPTH];
  cmd_t                 mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 empty_s, full_s, push_s, pop_s;
  cmd_t                 head_s;

  state_t               state_q, state_d;
  cmd_t                 cur_q, cur_d;
  logic [CORDW-1:0]     x_q, x_d, y_q, y_d, adx_s, ady_s;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d, e2_s, err_s;
  logic                 sx_q, sx_d, sy_q, sy_d;
  logic                 line_done_q, line_done_d, drawing_s;

  // FIFO status flags and input handshake
  always_comb begin
    empty_s   = (count_q == {CW{1'b0}});
    full_s    = (count_q == CW'(DEPTH));
    cmd_ready = !full_s && !rst;
    push_s    = cmd_valid && !full_s && !rst;
    head_s    = mem_q[rd_ptr_q];
  end

  // FIFO next-state: write on push, advance read pointer on pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, col: cmd_col};
      wr_ptr_d        = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; entries beyond the occupancy count are don't-care
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line FSM: fetch command, set up Bresenham terms, step pixels, signal end
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    line_done_d = 1'b0;
    pop_s       = 1'b0;
    drawing_s   = 1'b0;
    adx_s       = {CORDW{1'b0}};
    ady_s       = {CORDW{1'b0}};
    e2_s        = {EW{1'b0}};
    err_s       = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          cur_d   = head_s;
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (cur_q.x1 >= cur_q.x0) begin
          adx_s = cur_q.x1 - cur_q.x0;
        end else begin
          adx_s = cur_q.x0 - cur_q.x1;
        end
        if (cur_q.y1 >= cur_q.y0) begin
          ady_s = cur_q.y1 - cur_q.y0;
        end else begin
          ady_s = cur_q.y0 - cur_q.y1;
        end
        dx_d    = $signed({2'b00, adx_s});
        dy_d    = -$signed({2'b00, ady_s});
        err_d   = $signed({2'b00, adx_s}) - $signed({2'b00, ady_s});
        sx_d    = (cur_q.x0 < cur_q.x1);
        sy_d    = (cur_q.y0 < cur_q.y1);
        x_d     = cur_q.x0;
        y_d     = cur_q.y0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        drawing_s = oe;
        if (oe) begin
          if ((x_q == cur_q.x1) && (y_q == cur_q.y1)) begin
            line_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            // both axis decisions use the same e2; err collects both terms
            e2_s = err_q <<< 1;
            if (e2_s >= dy_q) begin
              err_s = err_s + dy_q;
              x_d   = sx_q ? (x_q + CORDW'(1'b1)) : (x_q - CORDW'(1'b1));
            end else begin
              x_d = x_q;
            end
            if (e2_s <= dx_q) begin
              err_s = err_s + dx_q;
              y_d   = sy_q ? (y_q + CORDW'(1'b1)) : (y_q - CORDW'(1'b1));
            end else begin
              y_d = y_q;
            end
            err_d = err_s;
          end
        end else begin
          state_d = S_DRAW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      x_q         <= {CORDW{1'b0}};
      y_q         <= {CORDW{1'b0}};
      dx_q        <= {EW{1'b0}};
      dy_q        <= {EW{1'b0}};
      err_q       <= {EW{1'b0}};
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      line_done_q <= line_done_d;
    end
  end

  // Output mapping
  always_comb begin
    x         = x_q;
    y         = y_q;
    col       = cur_q.col;
    drawing   = drawing_s;
    line_done = line_done_q;
    idle      = (state_q == S_IDLE) && empty_s;
  end

endmodule
